// File: rtl/bram_pkg.sv
// Shared types and constants for the BRAM tile read path.
package bram_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned DEF_ADDR_W = 20;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Per-beat position tags carried alongside each returned word
  typedef struct packed {
    logic row_last;
    logic last;
  } beat_tag_t;

endpackage

// File: rtl/bram_rd_fifo.sv
// Show-ahead synchronous FIFO buffering returned BRAM words and their tags.
module bram_rd_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign push    = wr_en;
  assign pop     = rd_en && (count != '0);
  assign rd_data = mem[rd_ptr];

  // Storage is not reset; pointers and count define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bram_tile_reader.sv
// Walks a 2-D tile of BRAM words, one read per cycle under a FIFO credit limit,
// and streams the returned words out on a valid/ready interface.
module bram_tile_reader
  import bram_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] row_stride,
  input  logic [CNT_W-1:0]  num_rows,
  input  logic [CNT_W-1:0]  num_cols,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_row_last,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PIPE_D = RD_LATENCY + 1;
  localparam int unsigned CNT_FW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SUM_W  = CNT_FW + 1;
  localparam int unsigned TAG_W  = $bits(beat_tag_t);
  localparam int unsigned FIFO_W = DATA_W + TAG_W;

  state_e            state_q, state_d;
  logic              load;
  logic              issue;
  logic              credit_ok;
  logic              fire;

  logic [CNT_W-1:0]  rows_q, cols_q;
  logic [CNT_W-1:0]  row_cnt_q, col_cnt_q;
  logic [ADDR_W-1:0] stride_q, row_base_q, col_addr_q, next_row_base;

  logic [PIPE_D-1:0] pipe_vld_q;
  beat_tag_t         pipe_tag_q [PIPE_D];
  beat_tag_t         issue_tag;
  beat_tag_t         head_tag;

  logic [CNT_FW-1:0] fifo_count;
  logic [CNT_FW-1:0] inflight;
  logic [FIFO_W-1:0] fifo_rdata;

  assign next_row_base      = row_base_q + stride_q;
  assign issue_tag.row_last = (col_cnt_q == cols_q - CNT_W'(1));
  assign issue_tag.last     = issue_tag.row_last && (row_cnt_q == rows_q - CNT_W'(1));

  // Reads already issued but not yet landed in the FIFO
  always_comb begin
    inflight = '0;
    for (int i = 0; i < PIPE_D; i++) begin
      inflight = inflight + CNT_FW'(pipe_vld_q[i]);
    end
  end

  assign credit_ok = (SUM_W'(fifo_count) + SUM_W'(inflight)) < SUM_W'(FIFO_DEPTH);

  assign m_valid    = (fifo_count != '0);
  assign fire       = m_valid && m_ready;
  assign head_tag   = beat_tag_t'(fifo_rdata[FIFO_W-1 -: TAG_W]);
  assign m_data     = fifo_rdata[DATA_W-1:0];
  assign m_row_last = m_valid && head_tag.row_last;
  assign m_last     = m_valid && head_tag.last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load = 1'b1;
          if ((num_rows == '0) || (num_cols == '0)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (issue_tag.last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (fire && head_tag.last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Address generator, latency pipe and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_q     <= '0;
      cols_q     <= '0;
      row_cnt_q  <= '0;
      col_cnt_q  <= '0;
      stride_q   <= '0;
      row_base_q <= '0;
      col_addr_q <= '0;
      rd_addr    <= '0;
      pipe_vld_q <= '0;
      for (int i = 0; i < PIPE_D; i++) begin
        pipe_tag_q[i] <= '0;
      end
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      pipe_vld_q    <= {pipe_vld_q[PIPE_D-2:0], issue};
      pipe_tag_q[0] <= issue_tag;
      for (int i = 1; i < PIPE_D; i++) begin
        pipe_tag_q[i] <= pipe_tag_q[i-1];
      end
      busy <= (state_d != ST_IDLE);
      done <= (state_d == ST_DONE);
      if (load) begin
        rows_q     <= num_rows;
        cols_q     <= num_cols;
        stride_q   <= row_stride;
        row_base_q <= base_addr;
        col_addr_q <= base_addr;
        row_cnt_q  <= '0;
        col_cnt_q  <= '0;
      end else if (issue) begin
        rd_addr <= col_addr_q;
        if (issue_tag.row_last) begin
          row_base_q <= next_row_base;
          col_addr_q <= next_row_base;
          col_cnt_q  <= '0;
          row_cnt_q  <= row_cnt_q + CNT_W'(1);
        end else begin
          col_addr_q <= col_addr_q + ADDR_W'(WORD_BYTES);
          col_cnt_q  <= col_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  bram_rd_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (pipe_vld_q[PIPE_D-1]),
    .wr_data ({pipe_tag_q[PIPE_D-1], bram_dout}),
    .rd_en   (fire),
    .rd_data (fifo_rdata),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_bram_tile_reader.sv
// Self-checking bench for bram_tile_reader: tile table plus random tiles
// against an address/beat model, and a mid-tile reset sequence.
module tb_bram_tile_reader;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 12;

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] stride;
    logic [CNT_W-1:0]  rows;
    logic [CNT_W-1:0]  cols;
    int                mode;      // 0 ready, 1 ready 1-of-3, 2 random, 3 held low 20 cycles
    bit                restart;
    int                exp_beats;
  } tile_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] row_stride;
  logic [CNT_W-1:0]  num_rows;
  logic [CNT_W-1:0]  num_cols;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] bram_dout;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_row_last;
  logic              m_last;
  logic              busy;
  logic              done;

  int                errors = 0;
  int                checks = 0;
  logic [ADDR_W-1:0] last_rd_addr;
  tile_t             tbl [10];

  always #5 clk = ~clk;

  // BRAM model: one-cycle read latency, word content derived from its address
  always @(posedge clk) bram_dout <= {12'hA5C, rd_addr};

  bram_tile_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .row_stride (row_stride),
    .num_rows   (num_rows),
    .num_cols   (num_cols),
    .rd_addr    (rd_addr),
    .bram_dout  (bram_dout),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_row_last (m_row_last),
    .m_last     (m_last),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ADDR_W-1:0] model_addr(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s,
                                                   input int r, input int c);
    longint sum;
    sum = longint'(b) + longint'(r) * longint'(s) + 64'd4 * longint'(c);
    return ADDR_W'(sum % (longint'(1) << ADDR_W));
  endfunction

  task automatic run_tile(input int id, input tile_t t);
    logic [ADDR_W-1:0] exp_addr [$];
    logic [33:0]       exp_beat [$];
    logic [33:0]       head, prev_head;
    logic [ADDR_W-1:0] hold_addr;
    int n, nbeats, cyc, first_valid, last_fire, done_cyc, done_cnt, k;
    bit busy_ok, stab_ok, prev_stall, finished;

    for (int r = 0; r < int'(t.rows); r++) begin
      for (int c = 0; c < int'(t.cols); c++) begin
        logic [ADDR_W-1:0] a;
        a = model_addr(t.base, t.stride, r, c);
        exp_addr.push_back(a);
        exp_beat.push_back({(c == int'(t.cols) - 1), (c == int'(t.cols) - 1) && (r == int'(t.rows) - 1),
                            12'hA5C, a});
      end
    end
    n = exp_beat.size();
    hold_addr = last_rd_addr;
    nbeats = 0; first_valid = -1; last_fire = -1; done_cyc = -1; done_cnt = 0;
    busy_ok = 1'b1; stab_ok = 1'b1; prev_stall = 1'b0; finished = 1'b0;
    prev_head = '0;

    base_addr = t.base; row_stride = t.stride; num_rows = t.rows; num_cols = t.cols;
    start = 1'b1;
    tick();
    start = 1'b0;
    base_addr = ADDR_W'($urandom); row_stride = ADDR_W'($urandom);
    num_rows = CNT_W'($urandom); num_cols = CNT_W'($urandom);

    cyc = 0;
    while (!finished && cyc < 2000) begin
      head = {m_row_last, m_last, m_data};
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (prev_stall && (!m_valid || head !== prev_head)) stab_ok = 1'b0;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if ((done_cyc < 0 || cyc <= done_cyc) && !busy) busy_ok = 1'b0;
      if (done_cyc >= 0 && cyc == done_cyc + 1)
        check($sformatf("t%0d busy_after_done", id), 64'(busy), 64'(0));
      if (t.mode == 0 && n > 0 && cyc >= 1 && cyc <= n + 1) begin
        k = (cyc <= n) ? cyc - 1 : n - 1;
        check($sformatf("t%0d rd_addr_c%0d", id, cyc), 64'(rd_addr), 64'(exp_addr[k]));
      end
      if (n == 0 && cyc <= 1)
        check($sformatf("t%0d rd_addr_hold_c%0d", id, cyc), 64'(rd_addr), 64'(hold_addr));
      if (t.mode == 3 && n >= 4 && cyc == 19)
        check($sformatf("t%0d credit_stall_addr", id), 64'(rd_addr), 64'(exp_addr[3]));

      if (t.restart && cyc == 4) begin
        start = 1'b1;
        base_addr = t.base ^ 20'h08000;
        num_rows = t.rows + 12'd1;
      end else begin
        start = 1'b0;
      end

      case (t.mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 3 == 2);
        2:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = (cyc >= 20);
      endcase

      if (m_valid && m_ready) begin
        if (nbeats < n)
          check($sformatf("t%0d beat%0d", id, nbeats), 64'(head), 64'(exp_beat[nbeats]));
        nbeats++;
        last_fire = cyc;
      end
      prev_stall = m_valid && !m_ready;
      prev_head = head;

      if (done_cyc >= 0 && cyc == done_cyc + 3) finished = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
    start = 1'b0;
    m_ready = 1'b0;

    check($sformatf("t%0d done_seen", id), 64'(done_cyc >= 0), 64'(1));
    check($sformatf("t%0d beat_count", id), 64'(nbeats), 64'(t.exp_beats));
    check($sformatf("t%0d done_pulses", id), 64'(done_cnt), 64'(1));
    check($sformatf("t%0d done_cycle", id), 64'(done_cyc), 64'((n == 0) ? 0 : last_fire + 1));
    check($sformatf("t%0d first_valid", id), 64'(first_valid), 64'((n == 0) ? -1 : 3));
    check($sformatf("t%0d busy_span", id), 64'(busy_ok), 64'(1));
    check($sformatf("t%0d stall_stable", id), 64'(stab_ok), 64'(1));
    last_rd_addr = (n > 0) ? exp_addr[n-1] : hold_addr;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " rd_addr"},    64'(rd_addr),    64'(0));
    check({tag, " m_valid"},    64'(m_valid),    64'(0));
    check({tag, " m_row_last"}, 64'(m_row_last), 64'(0));
    check({tag, " m_last"},     64'(m_last),     64'(0));
    check({tag, " busy"},       64'(busy),       64'(0));
    check({tag, " done"},       64'(done),       64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    tile_t t;
    int    fires, guard;

    tbl[0] = '{20'h00100, 20'h00040, 12'd2, 12'd3, 0, 1'b0, 6};
    tbl[1] = '{20'h00100, 20'h00040, 12'd2, 12'd3, 1, 1'b0, 6};
    tbl[2] = '{20'h00200, 20'h00040, 12'd0, 12'd3, 0, 1'b0, 0};
    tbl[3] = '{20'h00200, 20'h00040, 12'd4, 12'd0, 0, 1'b0, 0};
    tbl[4] = '{20'hFFFF8, 20'h00010, 12'd1, 12'd4, 0, 1'b0, 4};
    tbl[5] = '{20'h00100, 20'h00040, 12'd2, 12'd3, 0, 1'b1, 6};
    tbl[6] = '{20'h03000, 20'h00020, 12'd1, 12'd8, 3, 1'b0, 8};
    tbl[7] = '{20'hFFF00, 20'h00080, 12'd3, 12'd5, 2, 1'b0, 15};
    tbl[8] = '{20'h00040, 20'h00000, 12'd2, 12'd2, 0, 1'b0, 4};
    tbl[9] = '{20'h00000, 20'h00008, 12'd3, 12'd1, 1, 1'b0, 3};

    rst = 1'b1; start = 1'b0; m_ready = 1'b0;
    base_addr = '0; row_stride = '0; num_rows = '0; num_cols = '0;
    last_rd_addr = '0;
    repeat (3) tick();
    check_idle_outputs("in_reset");
    rst = 1'b0;
    tick();
    check_idle_outputs("after_reset");

    for (int i = 0; i < 10; i++) begin
      run_tile(i, tbl[i]);
    end

    for (int i = 10; i < 16; i++) begin
      t.base      = ADDR_W'($urandom) & 20'hFFFFC;
      t.stride    = ADDR_W'($urandom_range(0, 1023)) << 2;
      t.rows      = CNT_W'($urandom_range(1, 4));
      t.cols      = CNT_W'($urandom_range(1, 6));
      t.mode      = int'($urandom_range(0, 2));
      t.restart   = 1'($urandom_range(0, 1));
      t.exp_beats = int'(t.rows) * int'(t.cols);
      run_tile(i, t);
    end

    // Reset after the third beat of a 2x3 tile
    base_addr = 20'h00500; row_stride = 20'h00040; num_rows = 12'd2; num_cols = 12'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    m_ready = 1'b1;
    fires = 0; guard = 0;
    while (fires < 3 && guard < 50) begin
      if (m_valid && m_ready) fires++;
      tick();
      guard++;
    end
    check("rst_test third_beat", 64'(fires), 64'(3));
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_tile_reset");
    tick();
    tick();
    rst = 1'b0;
    m_ready = 1'b0;
    repeat (3) begin
      tick();
      if (done) check("rst_test no_done", 64'(done), 64'(0));
    end
    check_idle_outputs("post_reset_idle");
    last_rd_addr = '0;
    t = '{20'h09000, 20'h00100, 12'd2, 12'd3, 0, 1'b0, 6};
    run_tile(99, t);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
